// File: rtl/ascon_perm_arbiter.sv
// ascon_perm_arbiter
//   Two-requester round-robin arbiter in front of a single masked Ascon
//   permutation core. Only one request is in flight at a time. The winner's
//   state is registered into core_in, the core gets a one-cycle start pulse,
//   and the result is registered from core_out when core_done arrives. The
//   result is then presented on rsp_data until the granted requester takes
//   it with rsp_ready.
//
//   Optional feature: define ASCON_ARB_LOCK_EN to honour req_lock. A locked
//   grant keeps the core reserved for the same requester until that
//   requester is granted with req_lock low.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   req_valid/req_ready[1:0] request handshake, bit i = requester i
//   req_data0/req_data1     masked input states (320*d bits)
//   req_lock[1:0]           keep ownership after this request
//   rsp_valid/rsp_ready[1:0] response handshake, bit i = requester i
//   rsp_data                masked result, shared by both requesters
//   core_start/core_in      start pulse and registered input state to core
//   core_done/core_out      completion strobe and output state from core
//   busy                    high whenever the arbiter is not idle
module ascon_perm_arbiter #(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [320*d-1:0] req_data0,
  input  logic [320*d-1:0] req_data1,
  input  logic [1:0]       req_lock,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [320*d-1:0] rsp_data,
  output logic             core_start,
  output logic [320*d-1:0] core_in,
  input  logic             core_done,
  input  logic [320*d-1:0] core_out,
  output logic             busy
);

  localparam int W = 320 * d;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t         r_state;
  logic           r_ptr;
  logic           r_g;
  logic           r_core_start;
  logic           r_busy;
  logic [1:0]     r_rsp_valid;
  logic [W-1:0]   r_core_in;
  logic [W-1:0]   r_rsp_data;

  logic [1:0]     w_elig;
  logic [1:0]     w_gnt;
  logic           w_gidx;

`ifdef ASCON_ARB_LOCK_EN
  logic           r_lock;
`else
  logic           w_unused_lock;
  assign w_unused_lock = ^req_lock;
`endif

  // Grant is combinational so req_ready rises in the same IDLE cycle.
  always_comb begin
    w_elig = req_valid;
`ifdef ASCON_ARB_LOCK_EN
    // While locked, only the owner may be granted; the other is held off.
    if (r_lock) w_elig = req_valid & (r_g ? 2'b10 : 2'b01);
`endif
    w_gnt = '0;
    if (r_state == IDLE) begin
      if (w_elig == 2'b11) w_gnt = r_ptr ? 2'b10 : 2'b01;
      else                 w_gnt = w_elig;
    end
    w_gidx = w_gnt[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_ptr        <= 1'b0;
      r_g          <= 1'b0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_valid  <= '0;
      r_core_in    <= '0;
      r_rsp_data   <= '0;
`ifdef ASCON_ARB_LOCK_EN
      r_lock       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_g          <= w_gidx;
            r_core_in    <= w_gidx ? req_data1 : req_data0;
            r_core_start <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= START;
`ifdef ASCON_ARB_LOCK_EN
            r_lock       <= req_lock[w_gidx];
`endif
          end
        end
        START: begin
          r_core_start <= 1'b0;
          r_state      <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            r_rsp_data  <= core_out;
            r_rsp_valid <= r_g ? 2'b10 : 2'b01;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[r_g]) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
`ifdef ASCON_ARB_LOCK_EN
            r_ptr       <= r_lock ? r_g : ~r_g;
`else
            r_ptr       <= ~r_g;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = w_gnt;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign core_start = r_core_start;
  assign core_in    = r_core_in;
  assign busy       = r_busy;

endmodule

// File: doc/ascon_perm_arbiter.md
ASCON_PERM_ARBITER -- requirements
Module: ascon_perm_arbiter

Interface
REQ-001 The block SHALL have one parameter: d, default 2, number of Boolean shares per state bit; state buses are 320*d bits wide.
REQ-002 The block SHALL have these ports:
  clk  in  1  system clock; all flops on rising edge
  reset_n  in  1  asynchronous, active-low reset
  req_valid  in  2  request present, bit i = requester i
  req_ready  out  2  request accepted this cycle, bit i = requester i
  req_data0  in  320*d  masked input state, requester 0
  req_data1  in  320*d  masked input state, requester 1
  req_lock  in  2  keep core ownership after this request
  rsp_valid  out  2  result available for requester i
  rsp_ready  in  2  requester i consumes result
  rsp_data  out  320*d  masked permutation result, shared bus
  core_start  out  1  one-cycle start pulse to the masked permutation core
  core_in  out  320*d  registered input state to the core
  core_done  in  1  core finished; core_out valid while high
  core_out  in  320*d  masked output state from the core
  busy  out  1  high whenever state is not IDLE

Function
REQ-003 The FSM SHALL have states IDLE, START, WAIT, RESP.
REQ-004 IDLE: if any req_valid bit is high, the block SHALL grant exactly one requester, drive its req_ready bit high combinationally that cycle, register its req_data into core_in and the grant index into g, and go to START.
REQ-005 Arbitration SHALL be round-robin: pointer ptr names the preferred requester; both valid -> requester ptr wins; one valid -> that one wins.
REQ-006 req_ready SHALL be zero in every state except IDLE, and at most one bit SHALL be high in any cycle.
REQ-007 START: core_start SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-008 WAIT: on core_done=1, core_out SHALL be registered into rsp_data and state SHALL go to RESP; otherwise remain in WAIT with no timeout.
REQ-009 core_done SHALL be ignored in IDLE, START and RESP.
REQ-010 core_in SHALL remain stable from START until the next grant.
REQ-011 RESP: rsp_valid[g] SHALL be high and rsp_data stable until rsp_ready[g]=1; on that edge state SHALL go to IDLE and ptr SHALL become the other requester (subject to REQ-016); rsp_ready bits of the non-granted requester SHALL be ignored.
REQ-012 Latency: grant at cycle 0 -> core_start at cycle 1 -> core_done at cycle k -> rsp_valid high from cycle k+1; earliest next grant is the cycle after the rsp handshake.
REQ-013 req_valid deasserted in a non-IDLE state SHALL have no effect; no request is ever queued.

Reset
REQ-014 On reset_n=0, asynchronously: state=IDLE, ptr=0, g=0, core_in=0, rsp_data=0, core_start=0, rsp_valid=0, busy=0; req_ready follows REQ-004 from IDLE.
REQ-015 Reset asserted mid-operation SHALL abort it without a response; the in-flight result is discarded.

Configuration
REQ-016 With macro ASCON_ARB_LOCK_EN defined: if req_lock[g]=1 at grant, ptr SHALL stay at g after RESP and IDLE SHALL grant only requester g (the other is held off) until a grant to g with req_lock[g]=0, after which ptr moves to the other requester and normal round-robin resumes.
REQ-017 Without ASCON_ARB_LOCK_EN: req_lock SHALL be ignored and arbitration SHALL be pure round-robin.

Verification
REQ-018 Reset release, req_valid=2'b11 same cycle -> req_ready=2'b01, core_start at +1 cycle, core_in=req_data0.
REQ-019 Core stub returning done 12 cycles after start, rsp_ready=1 -> rsp_valid[0] at start+13, rsp_data=core_out captured value, next grant goes to requester 1 when both valid.
REQ-020 rsp_ready held 0 for 20 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0 throughout, core_start never re-pulses.
REQ-021 reset_n pulsed low during WAIT -> all outputs zero immediately, later core_done ignored, next request from requester 1 granted first (ptr=0 rule with only req_valid[1] high).
REQ-022 ASCON_ARB_LOCK_EN defined, requester 0 issues 3 requests with req_lock=1,1,0 while req_valid[1]=1 continuously -> grant order 0,0,0,1; undefined -> grant order 0,1,0,1.
